// File: rtl/if_stage.sv
// Instruction fetch stage with one outstanding imem request and a single-entry hold buffer for words that arrive during a stall.
// Optional performance counters are enabled with IF_PERF_CNT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic        JAL,
  input  logic        JALR,
  input  logic [31:0] branchTarget,
  input  logic [31:0] JALRTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_ID,
  output logic [31:0] pc_ID,
  output logic        valid_ID,
  output logic [4:0]  RegDestination_ID,
  output logic [4:0]  Rs1_ID,
  output logic [4:0]  Rs2_ID
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] hold_ins, hold_pc;
  logic        redirect;
  logic [31:0] target;
  logic        deliver;
  logic [31:0] deliver_ins, deliver_pc;
  logic        capture;

  // Redirects only count for a live instruction in ID, and never while stalled.
  assign redirect = (branch | JAL | JALR) & valid_ID & ~stall;
  assign target   = JALR ? JALRTarget : branchTarget;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    imem_req    = 1'b0;
    deliver     = 1'b0;
    deliver_ins = imem_rdata;
    deliver_pc  = pc;
    capture     = 1'b0;
    case (state)
      S_REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = S_DROP;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_valid) begin
          if (redirect) begin
            pc_nxt    = target;
            state_nxt = S_REQ;
          end else if (stall) begin
            capture   = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            deliver   = 1'b1;
            pc_nxt    = pc + 32'd4;
            state_nxt = S_REQ;
          end
        end else if (redirect) begin
          // The in-flight response still has to be swallowed in DROP.
          pc_nxt    = target;
          state_nxt = S_DROP;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          if (redirect) begin
            pc_nxt    = target;
            state_nxt = S_REQ;
          end else begin
            deliver     = 1'b1;
            deliver_ins = hold_ins;
            deliver_pc  = hold_pc;
            pc_nxt      = pc + 32'd4;
            state_nxt   = S_REQ;
          end
        end
      end
      S_DROP: begin
        if (imem_valid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      hold_ins       <= 32'h0;
      hold_pc        <= 32'h0;
      instruction_ID <= NOP;
      pc_ID          <= 32'h0;
      valid_ID       <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (capture) begin
        hold_ins <= imem_rdata;
        hold_pc  <= pc;
      end
      // Bubbles keep pc_ID so the last fetched PC stays visible downstream.
      if (!stall) begin
        if (deliver) begin
          instruction_ID <= deliver_ins;
          pc_ID          <= deliver_pc;
          valid_ID       <= 1'b1;
        end else begin
          instruction_ID <= NOP;
          valid_ID       <= 1'b0;
        end
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= 32'h0;
      flush_count <= 32'h0;
    end else begin
      if (deliver) fetch_count <= fetch_count + 32'd1;
      if (redirect) flush_count <= flush_count + 32'd1;
    end
  end
`endif

  assign imem_addr         = pc;
  assign RegDestination_ID = instruction_ID[11:7];
  assign Rs1_ID            = instruction_ID[19:15];
  assign Rs2_ID            = instruction_ID[24:20];

endmodule
